// File: rtl/u111_dyn_bus_sizer.sv
// Bus-sizing cycle engine between the 68040 local bus and the Amiga bus: byte/word/long sub-cycles.
// Define TACK_TIMEOUT_EN to enable the WAIT-state timeout that forces TEA after TIMEOUT_CLKS clocks.
module u111_dyn_bus_sizer #(
  parameter int unsigned TIMEOUT_CLKS = 255,
  parameter int unsigned GAP_CLKS     = 1
) (
  input  logic        CLK80,
  input  logic        RESETn,
  input  logic        TS_CPUn,
  input  logic        RnW,
  input  logic        LBENn,
  input  logic        BGn,
  input  logic [1:0]  SIZ,
  input  logic [1:0]  A_040,
  input  logic [1:0]  PORTSIZE,
  input  logic [31:0] D_CPU_W,
  output logic [31:0] D_CPU_R,
  output logic        D_CPU_OE,
  output logic [31:0] D_BUS_W,
  output logic        D_BUS_OE,
  input  logic [31:0] D_BUS_R,
  output logic        TSn,
  output logic [1:0]  A_AMIGA,
  input  logic        TACKn,
  input  logic        TEAn,
  output logic        TA_CPUn,
  output logic        TEA_CPUn,
  output logic        TBI_CPUn,
  output logic        BUSY
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_GAP, S_DONE, S_ERR} state_e;

  localparam logic [2:0] GAP_LAST = 3'((GAP_CLKS == 0) ? 0 : GAP_CLKS - 1);

  if (TIMEOUT_CLKS < 1 || TIMEOUT_CLKS > 1023 || GAP_CLKS > 7) begin : g_bad_param
    $error("u111_dyn_bus_sizer: TIMEOUT_CLKS or GAP_CLKS out of range");
  end

  state_e      state_q, state_d;
  logic        rnw_q;
  logic [1:0]  siz_q, addr_q, psize_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  sub_q, sub_d;
  logic [2:0]  gap_q, gap_d;
`ifdef TACK_TIMEOUT_EN
  localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT_CLKS);
  logic [9:0]  tmo_q, tmo_d;
`endif

  logic        take;
  logic [2:0]  n_bytes, width, step;
  logic [1:0]  lane_mask, sub_addr, lane_off;
  logic [4:0]  done_bytes;
  logic        last_sub;
  logic [2:0]  act_lo, act_hi;
  logic [31:0] rd_shift, rd_merge;

  assign take = (state_q == S_IDLE) && !TS_CPUn && LBENn && !BGn;

  // Line transfers move as a long; lane_mask is ~(W-1) restricted to the two address bits.
  always_comb begin
    case (siz_q)
      2'b01:   n_bytes = 3'd1;
      2'b10:   n_bytes = 3'd2;
      default: n_bytes = 3'd4;
    endcase
    case (psize_q)
      2'b01:   begin width = 3'd2; lane_mask = 2'b10; end
      2'b10:   begin width = 3'd1; lane_mask = 2'b11; end
      default: begin width = 3'd4; lane_mask = 2'b00; end
    endcase
  end

  assign step       = (width < n_bytes) ? width : n_bytes;
  assign sub_addr   = addr_q + 2'({1'b0, sub_q} * step);
  assign lane_off   = sub_addr & lane_mask;
  assign done_bytes = ({3'b000, sub_q} + 5'd1) * {2'b00, step};
  assign last_sub   = done_bytes >= {2'b00, n_bytes};
  assign act_lo     = {1'b0, sub_addr};
  assign act_hi     = act_lo + step;

  // Lane 0 is D31..24, so moving CPU lane L down to bus lane L-off is a left shift.
  assign D_BUS_W  = wdata_q << {lane_off, 3'b000};
  assign rd_shift = D_BUS_R >> {lane_off, 3'b000};

  always_comb begin
    rd_merge = rdata_q;
    for (int l = 0; l < 4; l++) begin
      if (3'(l) >= act_lo && 3'(l) < act_hi) begin
        rd_merge[31-8*l -: 8] = rd_shift[31-8*l -: 8];
      end
    end
  end

  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    gap_d   = gap_q;
    rdata_d = rdata_q;
`ifdef TACK_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d = S_START;
          sub_d   = '0;
          rdata_d = '0;
        end
      end
      S_START: begin
        state_d = S_WAIT;
`ifdef TACK_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        if (!TEAn) begin
          state_d = S_ERR;
        end else if (!TACKn) begin
          if (rnw_q) rdata_d = rd_merge;
          if (last_sub) begin
            state_d = S_DONE;
          end else begin
            sub_d   = sub_q + 2'd1;
            gap_d   = '0;
            state_d = (GAP_CLKS == 0) ? S_START : S_GAP;
          end
        end
`ifdef TACK_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + 10'd1;
          if (tmo_d == TMO_LIMIT) state_d = S_ERR;
        end
`endif
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_START;
        else                   gap_d   = gap_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments only; the latched request and data
  // registers are reset too, so every output is defined straight out of reset.
  always_ff @(posedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      rnw_q   <= 1'b1;
      siz_q   <= '0;
      addr_q  <= '0;
      psize_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sub_q   <= '0;
      gap_q   <= '0;
`ifdef TACK_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      sub_q   <= sub_d;
      gap_q   <= gap_d;
`ifdef TACK_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
      if (take) begin
        rnw_q   <= RnW;
        siz_q   <= SIZ;
        addr_q  <= A_040;
        psize_q <= PORTSIZE;
        wdata_q <= D_CPU_W;
      end
    end
  end

  assign TSn      = (state_q != S_START);
  assign A_AMIGA  = sub_addr;
  assign D_BUS_OE = !rnw_q && (state_q == S_START || state_q == S_WAIT);
  assign D_CPU_R  = rdata_q;
  assign D_CPU_OE = (state_q == S_DONE) && rnw_q;
  assign TA_CPUn  = (state_q != S_DONE);
  assign TBI_CPUn = !((state_q == S_DONE) && (siz_q == 2'b11));
  assign TEA_CPUn = (state_q != S_ERR);
  assign BUSY     = (state_q != S_IDLE);

endmodule

// File: doc/u111_dyn_bus_sizer.md
# u111_dyn_bus_sizer

Parametrised bus-sizing cycle engine between the 68040 local bus and the Amiga/APCI bus. It splits any CPU transfer into the sub-cycles the addressed port needs (byte, word or long). It steers data lanes, assembles read data, and returns a single termination to the CPU. Off-board cycles enter it; on-board memory cycles (_LBEN asserted) bypass it.

## Interface
- TIMEOUT_CLKS, 255: CLK80 clocks allowed in WAIT before a forced TEA (1..1023).
- GAP_CLKS, 1: idle clocks between sub-cycles (0..7).
- CLK80  in  1  sole clock; all state changes on its rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- TS_CPUn, RnW, LBENn, BGn  in  1 each  CPU transfer start, direction, on-board select, bus grant.
- SIZ  in  2  00 long, 01 byte, 10 word, 11 line.
- A_040  in  2  CPU A1..A0.
- PORTSIZE  in  2  00 long, 01 word, 10 byte (11 treated as long); sampled with TS_CPUn.
- D_CPU_W  in  32  CPU write data.
- D_CPU_R  out  32  assembled read data.
- D_CPU_OE  out  1  drive D_CPU_R onto the CPU bus.
- D_BUS_W  out  32  steered write data.
- D_BUS_OE  out  1  drive D_BUS_W.
- D_BUS_R  in  32  Amiga bus read data.
- TSn  out  1  Amiga bus transfer start.
- A_AMIGA  out  2  sub-cycle A1..A0.
- TACKn, TEAn  in  1 each  Amiga bus acknowledge and error.
- TA_CPUn, TEA_CPUn, TBI_CPUn  out  1 each  CPU termination.
- BUSY  out  1  high while not IDLE.

## Operation
- States: IDLE, START, WAIT, GAP, DONE, ERR.
- IDLE: on sampled TS_CPUn=0, LBENn=1 and BGn=0, latch RnW, SIZ, A_040, PORTSIZE and D_CPU_W, then go to START. Otherwise remain in IDLE.
- Byte count B: SIZ 01=1, 10=2, 00=4, 11=4 (line is handled as a long).
- Port width W is 4, 2 or 1. Sub-cycle count N = max(1, B/W), between 1 and 4. Sub-cycle k uses address a_k = A_040 + k·min(W,B), modulo 4.
- Lane steering: CPU lane L (0=D31..24) maps to bus lane L − (a_k & ~(W−1)). For a long port this is pass-through.
- Write: D_BUS_W carries the steered lanes. D_BUS_OE=1 from START to the end of WAIT for each sub-cycle.
- Read: on the TACK edge, the steered bus lanes are written into the assembly register at the CPU lanes. Untouched lanes keep 0x00.
- START: TSn=0 for exactly one clock and A_AMIGA=a_k, then go to WAIT.
- WAIT:
  - TEAn=0 goes to ERR. This has priority over TACKn when both are low.
  - TACKn=0 goes to DONE after the last sub-cycle, otherwise to GAP. If GAP_CLKS=0, it goes straight to START.
- GAP: GAP_CLKS clocks, then k+1 and START.
- DONE: TA_CPUn=0 and D_CPU_OE=RnW for one clock. TBI_CPUn=0 in the same clock if SIZ=11. Then go to IDLE.
- ERR: TEA_CPUn=0 for one clock, remaining sub-cycles are abandoned, then go to IDLE.
- A TS_CPUn that arrives while BUSY is ignored.

## Timing
- Reset values:
  - TSn, TA_CPUn, TEA_CPUn and TBI_CPUn are 1.
  - D_CPU_OE, D_BUS_OE and BUSY are 0.
  - A_AMIGA is 00, D_CPU_R is 0, D_BUS_W is 0, and the state is IDLE.
- An assertion of RESETn mid-operation aborts immediately. No termination is sent to the CPU.
- TS_CPUn is sampled at edge n.
  - TSn is low during n+1.
  - The earliest TACK sample is at n+2.
  - TA_CPUn is low during n+3 for an N=1 cycle.
- Each further sub-cycle adds 2+GAP_CLKS clocks plus any TACK wait.
- A_AMIGA and D_BUS_W are stable from START through the TACK edge.
- D_CPU_R is registered and stable for the whole DONE clock.

## Configuration
- TACK_TIMEOUT_EN defined: a WAIT counter runs, cleared on entry to each WAIT. When it reaches TIMEOUT_CLKS, the engine goes to ERR and asserts TEA_CPUn.
- TACK_TIMEOUT_EN undefined: there is no counter, WAIT can last indefinitely, and TIMEOUT_CLKS is ignored.

## Test plan
- Long read (SIZ=00, A=0) from a word port:
  - Stimulus: bus returns 0xAABB then 0xCCDD on lanes 0..1.
  - Response: two TSn pulses with A_AMIGA=00 then 10.
  - Response: D_CPU_R=0xAABBCCDD with a single TA_CPUn.
- Byte write to a byte port (SIZ=01, A=3, D_CPU_W=0x000000EE):
  - Response: one sub-cycle with A_AMIGA=11 and D_BUS_W[31:24]=0xEE.
- Long write (D_CPU_W=0x12345678) to a byte port with GAP_CLKS=2:
  - Response: four sub-cycles, bytes 12, 34, 56, 78 on lane 0 at A_AMIGA 00..11.
  - Response: two idle clocks between TSn pulses.
- Long read from a word port with TEAn=0 on the second sub-cycle:
  - Response: TEA_CPUn low for one clock, no TA_CPUn, BUSY=0 on the next clock.
- TACK_TIMEOUT_EN with TIMEOUT_CLKS=8 and TACKn held high:
  - Response: TEA_CPUn asserts on the 9th clock after WAIT entry.
- Line read (SIZ=11) to a long port:
  - Response: one sub-cycle, and TA_CPUn and TBI_CPUn low in the same clock.
